// File: rtl/instr_prefetch_queue_pkg.sv
// rtl/instr_prefetch_queue_pkg.sv - shared types and defaults for the instruction prefetch queue
package instr_prefetch_queue_pkg;

    localparam int PF_DEPTH = 4;
    localparam int PF_PC_W  = 8;

    typedef logic [7:0] instr_t;

    typedef enum logic [1:0] {
        PF_IDLE,
        PF_REQ,
        PF_DRAIN
    } pf_state_e;

endpackage

// File: rtl/instr_prefetch_queue_fifo.sv
// rtl/instr_prefetch_queue_fifo.sv - synchronous FIFO with flush, occupancy count and head data
module instr_prefetch_queue_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [W-1:0]     head_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // The caller guarantees push never targets a full FIFO and pop never an empty one.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - sequential instruction fetch FSM feeding a prefetch FIFO with redirect/squash
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int              PC_W     = PF_PC_W,
    parameter int              DEPTH    = PF_DEPTH,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            stop,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  instr_t          imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output instr_t          out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic            empty
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = 8 + PC_W;

    pf_state_e           state;
    logic [PC_W-1:0]     fetch_pc;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    cnt_next;
    logic [ENTRY_W-1:0]  head;
    logic                push;
    logic                pop;
    logic                can_issue;

    // Redirect beats both a completing fetch and a decoder pop in the same cycle.
    assign push      = (state == PF_REQ) && imem_ack && !redirect;
    assign pop       = out_valid && out_ready && !redirect;
    assign cnt_next  = count + CNT_W'(push) - CNT_W'(pop);
    assign can_issue = !stop && !redirect && (cnt_next < CNT_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= PF_IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            case (state)
                PF_IDLE: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                    end else if (can_issue) begin
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                        state     <= PF_REQ;
                    end
                end
                PF_REQ: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= PF_IDLE;
                        fetch_pc <= redirect ? redirect_pc : imem_addr + PC_W'(1);
                    end else if (redirect) begin
                        // The memory still owes a response; keep the port stable and drop it later.
                        fetch_pc <= redirect_pc;
                        state    <= PF_DRAIN;
                    end
                end
                PF_DRAIN: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                    end
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= PF_IDLE;
                    end
                end
                default: state <= PF_IDLE;
            endcase
        end
    end

    instr_prefetch_queue_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .push      (push),
        .push_data ({imem_rdata, imem_addr}),
        .pop       (pop),
        .flush     (redirect),
        .count     (count),
        .head_data (head)
    );

    assign out_valid = (count != '0);
    assign out_instr = head[ENTRY_W-1 -: 8];
    assign out_pc    = head[PC_W-1:0];
    assign empty     = (count == '0) && !imem_req;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb/tb_instr_prefetch_queue.sv - scoreboard bench for instr_prefetch_queue against a sequential-PC model
module tb_instr_prefetch_queue;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       stop;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_instr;
    logic [7:0] out_pc;
    logic       empty;

    logic [7:0] mem [256];
    logic [7:0] exp_q [$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         lat_fixed = 0;
    int         ack_cnt = 0;

    always #5 clk = ~clk;

    instr_prefetch_queue dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stop        (stop),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .empty       (empty)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // After a restart at pc the decoder must see pc, pc+1, ... (mod 256), each with mem[pc].
    task automatic reload(input logic [7:0] pc);
        logic [7:0] p;
        exp_q.delete();
        p = pc;
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(p);
            p = p + 8'd1;
        end
    endtask

    task automatic wait_req(input logic val, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (imem_req !== val && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (imem_req !== val) check({name, "_timeout"}, 32'(imem_req), 32'(val));
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_imem_req"},  32'(imem_req),  0);
        check({tag, "_imem_addr"}, 32'(imem_addr), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_instr"}, 32'(out_instr), 0);
        check({tag, "_out_pc"},    32'(out_pc),    0);
        check({tag, "_empty"},     32'(empty),     1);
    endtask

    // Memory model: variable-latency acks, address must stay put while a request is open.
    initial begin : responder
        int         wait_cnt;
        bit         pending;
        logic [7:0] held_addr;
        imem_ack   = 1'b0;
        imem_rdata = 8'h00;
        pending    = 1'b0;
        wait_cnt   = 0;
        held_addr  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            imem_rdata = 8'($urandom);
            if (!imem_req) begin
                pending  = 1'b0;
                imem_ack = 1'b0;
            end else begin
                if (!pending) begin
                    pending   = 1'b1;
                    wait_cnt  = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
                    held_addr = imem_addr;
                end else begin
                    check("addr_stable", 32'(imem_addr), 32'(held_addr));
                end
                if (wait_cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem[imem_addr];
                    pending    = 1'b0;
                    ack_cnt++;
                end else begin
                    imem_ack = 1'b0;
                    wait_cnt--;
                end
            end
        end
    end

    initial begin : monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (n_rst && out_valid && out_ready && !redirect) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'(out_pc), 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", 32'(out_pc), 32'(e));
                    check("sb_instr", 32'(out_instr), 32'(mem[e]));
                end
            end
        end
    end

    initial begin : stim
        int a0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        n_rst = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; stop = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");

        // In-order fetch with 1-cycle acks.
        @(posedge clk); #1;
        reload(8'h00); ack_cnt = 0; n_rst = 1'b1; out_ready = 1'b1; lat_fixed = 0;
        cycles(30);

        // Fill with decoder stalled: exactly DEPTH fetches, then quiet.
        n_rst = 1'b0; out_ready = 1'b0;
        cycles(2);
        reload(8'h00); ack_cnt = 0; n_rst = 1'b1;
        cycles(20);
        @(negedge clk);
        check("full_acks", 32'(ack_cnt), 4);
        check("full_req", 32'(imem_req), 0);
        check("full_valid", 32'(out_valid), 1);
        check("full_empty", 32'(empty), 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        cycles(30);

        // Redirect while a slow request is open: it drains and its data is dropped.
        lat_fixed = 3;
        wait_req(1'b0, "t3_idle");
        wait_req(1'b1, "t3_req");
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 8'h20; reload(8'h20);
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        check("drain_req_held", 32'(imem_req), 1);
        check("drain_valid", 32'(out_valid), 0);
        wait_req(1'b0, "t3_drain_done");
        wait_req(1'b1, "t3_new_req");
        check("redirect_addr", 32'(imem_addr), 32'h20);
        cycles(30);

        // Redirect in the same cycle as an ack and a pop.
        lat_fixed = 2; out_ready = 1'b0;
        begin
            int n;
            bit hit;
            n = 0; hit = 1'b0;
            while (!hit && n < 100) begin
                @(posedge clk); #2;
                if (imem_ack && out_valid) hit = 1'b1;
                n++;
            end
            check("t4_found", 32'(hit), 1);
        end
        redirect = 1'b1; redirect_pc = 8'h40; out_ready = 1'b1; reload(8'h40);
        @(posedge clk); #1;
        redirect = 1'b0;
        @(negedge clk);
        check("t4_valid", 32'(out_valid), 0);
        check("t4_req", 32'(imem_req), 0);
        wait_req(1'b1, "t4_req");
        check("t4_addr", 32'(imem_addr), 32'h40);
        cycles(20);

        // Address wrap at the top of the PC space.
        lat_fixed = 0;
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 8'hfe; reload(8'hfe);
        @(posedge clk); #1;
        redirect = 1'b0;
        wait_req(1'b1, "t5_fe");
        check("wrap_fe", 32'(imem_addr), 32'hfe);
        wait_req(1'b0, "t5_gap1"); wait_req(1'b1, "t5_ff");
        check("wrap_ff", 32'(imem_addr), 32'hff);
        wait_req(1'b0, "t5_gap2"); wait_req(1'b1, "t5_00");
        check("wrap_00", 32'(imem_addr), 32'h00);
        cycles(10);

        // Stop with a request open: that one lands, nothing further issues.
        lat_fixed = 3;
        wait_req(1'b0, "t6_idle");
        wait_req(1'b1, "t6_req");
        @(posedge clk); #1;
        stop = 1'b1; a0 = ack_cnt;
        cycles(15);
        @(negedge clk);
        check("stop_acks", 32'(ack_cnt - a0), 1);
        check("stop_req", 32'(imem_req), 0);
        check("stop_empty", 32'(empty), 1);
        @(posedge clk); #1;
        stop = 1'b0;
        cycles(10);

        // Reset in the middle of an open request.
        wait_req(1'b0, "t7_idle");
        wait_req(1'b1, "t7_req");
        @(posedge clk); #1;
        n_rst = 1'b0;
        @(posedge clk); #1;
        reload(8'h00);
        @(negedge clk);
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        n_rst = 1'b1;
        wait_req(1'b1, "t7_first");
        check("midreset_addr", 32'(imem_addr), 0);

        // Randomized traffic: backpressure, stop, redirects, random latency.
        lat_fixed = -1;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 49) == 0) stop = ~stop;
            redirect = ($urandom_range(0, 29) == 0);
            if (redirect) begin
                redirect_pc = 8'($urandom);
                reload(redirect_pc);
            end
        end
        @(posedge clk); #1;
        redirect = 1'b0; stop = 1'b0;
        cycles(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
